otp_pad_arbiter: RTL

OTP_PAD_ARBITER -- requirements
Module: otp_pad_arbiter

---
 rtl/otp_pad_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/otp_pad_arbiter.sv
// Arbitrates encrypt/decrypt requesters onto an 8-slot one-time-pad register file.
// Each accepted op runs IDLE -> ACCESS -> RESP; outputs are registered, and enc stalls while every slot is used.
module otp_pad_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_req,
  output logic       enc_gnt,
  input  logic       dec_req,
  input  logic [2:0] dec_idx,
  output logic       dec_gnt,
  output logic       rf_we,
  output logic [2:0] rf_wa,
  output logic [2:0] rf_ra,
  output logic       prng_adv,
  output logic       out_valid,
  output logic [2:0] out_slot,
  output logic       out_mode,
  output logic       dec_err,
  output logic       full,
  output logic       empty,
  output logic [3:0] used_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t     state_q;
  logic       op_q;          // 0 = encrypt, 1 = decrypt
  logic [2:0] slot_q;
  logic       last_dec_q;
  logic [7:0] slot_valid_q, slot_valid_d;
  logic [3:0] used_cnt_q, cnt_d;
  logic       full_q, empty_q;
  logic       enc_gnt_q, dec_gnt_q, rf_we_q, prng_adv_q;
  logic [2:0] rf_wa_q, rf_ra_q;
  logic       out_valid_q, out_mode_q, dec_err_q;
  logic [2:0] out_slot_q;

  logic       enc_elig, dec_elig, pick_enc, found;
  logic [2:0] free_slot;

  always_comb begin
    free_slot = 3'd0;
    found     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && !slot_valid_q[i]) begin
        free_slot = 3'(i);
        found     = 1'b1;
      end
    end

    enc_elig = enc_req & ~full_q;
    dec_elig = dec_req;
    // Round-robin: enc wins a tie only if dec won the previous accept
    pick_enc = enc_elig & (~dec_elig | last_dec_q);

    slot_valid_d = slot_valid_q;
    if (state_q == S_ACCESS) begin
      slot_valid_d[slot_q] = ~op_q;
    end

    cnt_d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_d = cnt_d + {3'd0, slot_valid_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      slot_q       <= 3'd0;
      last_dec_q   <= 1'b1;
      slot_valid_q <= 8'd0;
      used_cnt_q   <= 4'd0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      enc_gnt_q    <= 1'b0;
      dec_gnt_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= 3'd0;
      rf_ra_q      <= 3'd0;
      prng_adv_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_slot_q   <= 3'd0;
      out_mode_q   <= 1'b0;
      dec_err_q    <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      used_cnt_q   <= cnt_d;
      full_q       <= (cnt_d == 4'd8);
      empty_q      <= (cnt_d == 4'd0);

      enc_gnt_q    <= 1'b0;
      dec_gnt_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_wa_q      <= 3'd0;
      rf_ra_q      <= 3'd0;
      prng_adv_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_slot_q   <= 3'd0;
      out_mode_q   <= 1'b0;
      dec_err_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (enc_elig || dec_elig) begin
            state_q    <= S_ACCESS;
            op_q       <= ~pick_enc;
            slot_q     <= pick_enc ? free_slot : dec_idx;
            last_dec_q <= ~pick_enc;
            enc_gnt_q  <= pick_enc;
            dec_gnt_q  <= ~pick_enc;
            rf_we_q    <= pick_enc;
            prng_adv_q <= pick_enc;
            rf_wa_q    <= pick_enc ? free_slot : 3'd0;
            rf_ra_q    <= pick_enc ? 3'd0 : dec_idx;
          end
        end
        S_ACCESS: begin
          state_q     <= S_RESP;
          out_valid_q <= 1'b1;
          out_slot_q  <= slot_q;
          out_mode_q  <= op_q;
          dec_err_q   <= op_q & ~slot_valid_q[slot_q];
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign enc_gnt   = enc_gnt_q;
  assign dec_gnt   = dec_gnt_q;
  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_ra     = rf_ra_q;
  assign prng_adv  = prng_adv_q;
  assign out_valid = out_valid_q;
  assign out_slot  = out_slot_q;
  assign out_mode  = out_mode_q;
  assign dec_err   = dec_err_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign used_cnt  = used_cnt_q;

endmodule
